// File: rtl/saradc_pkg.sv
// saradc_pkg: shared FSM state type and default sizing for the SAR sequencer
package saradc_pkg;
  localparam int NBITS_DEF = 8;
  localparam int AVGW_DEF  = 2;
  typedef enum logic [2:0] {ST_IDLE, ST_SAMPL, ST_CONV, ST_ACC, ST_DONE} state_t;
endpackage

// File: rtl/saradc_sar_reg.sv
// saradc_sar_reg: successive-approximation code register with a one-hot trial-bit pointer
module saradc_sar_reg #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_trial,
  input  logic             i_cmp,
  output logic [NBITS-1:0] o_code,
  output logic             o_last
);
  localparam logic [NBITS-1:0] MSB = {1'b1, {(NBITS-1){1'b0}}};
  logic [NBITS-1:0] r_code;
  logic [NBITS-1:0] r_mask;
  // clear, load the MSB trial, or resolve the current trial bit and arm the next lower one
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_code <= '0;
      r_mask <= '0;
    end else if (i_clr) begin
      r_code <= '0;
      r_mask <= '0;
    end else if (i_load) begin
      r_code <= MSB;
      r_mask <= MSB;
    end else if (i_trial) begin
      r_code <= (r_code & ~r_mask) | (r_mask & {NBITS{i_cmp}}) | (r_mask >> 1);
      r_mask <= r_mask >> 1;
    end
  assign o_code = r_code;
  assign o_last = r_mask[0];
endmodule

// File: rtl/saradc_sar_seq.sv
// saradc_sar_seq: SAR ADC sequencer with sample/convert/accumulate and power-of-two averaging
module saradc_sar_seq
  import saradc_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int AVGW  = AVGW_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [3:0]       SAMPLE_CYC,
  input  logic [AVGW-1:0]  AVG_LOG2,
  input  logic             CMPO,
  output logic             SAMPLE,
  output logic [NBITS-1:0] RESULTP,
  output logic [NBITS-1:0] RESULTN,
  output logic             VALID,
  output logic [NBITS-1:0] DATA,
  output logic             BUSY
);
  localparam int CW   = 2**AVGW - 1;
  localparam int ACCW = NBITS + CW;
  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_scnt;
  logic [3:0]        r_s;
  logic [AVGW-1:0]   r_avg;
  logic [CW-1:0]     r_cnt;
  logic [ACCW-1:0]   r_acc;
  logic [NBITS-1:0]  r_data;
  logic              r_valid;
  logic [NBITS-1:0]  w_code;
  logic              w_last;
  logic              w_accept;
  logic              w_samp_end;
  logic              w_cnt_end;
  assign w_accept   = r_state == ST_IDLE && START && !ABORT;
  assign w_samp_end = r_scnt == r_s;
  assign w_cnt_end  = r_cnt == CW'((1 << r_avg) - 1);
  saradc_sar_reg #(.NBITS(NBITS)) u_sar (
    .clk     (CLK),
    .rst     (RST),
    .i_clr   (w_accept || (r_state == ST_ACC && !w_cnt_end && !ABORT)),
    .i_load  (r_state == ST_SAMPL && w_samp_end && !ABORT),
    .i_trial (r_state == ST_CONV && !ABORT),
    .i_cmp   (CMPO),
    .o_code  (w_code),
    .o_last  (w_last)
  );
  // state register
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  // next-state: ABORT overrides every transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = START ? ST_SAMPL : ST_IDLE;
      ST_SAMPL: w_next = w_samp_end ? ST_CONV : ST_SAMPL;
      ST_CONV:  w_next = w_last ? ST_ACC : ST_CONV;
      ST_ACC:   w_next = w_cnt_end ? ST_DONE : ST_SAMPL;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (ABORT) w_next = ST_IDLE;
  end
  // config latch, sample timer, accumulator, conversion count and averaged output
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_scnt  <= '0;
      r_s     <= '0;
      r_avg   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_state == ST_DONE && !ABORT;
      if (w_accept) begin
        r_s    <= SAMPLE_CYC;
        r_avg  <= AVG_LOG2;
        r_acc  <= '0;
        r_cnt  <= '0;
        r_scnt <= '0;
      end
      if (r_state == ST_SAMPL) r_scnt <= r_scnt + 1'b1;
      if (r_state == ST_ACC) begin
        r_acc  <= r_acc + ACCW'(w_code);
        r_cnt  <= w_cnt_end ? '0 : r_cnt + 1'b1;
        r_scnt <= '0;
      end
      if (r_state == ST_DONE && !ABORT) r_data <= NBITS'(r_acc >> r_avg);
    end
  assign SAMPLE  = r_state == ST_SAMPL;
  assign RESULTP = w_code;
  assign RESULTN = ~w_code;
  assign VALID   = r_valid;
  assign DATA    = r_data;
  assign BUSY    = r_state != ST_IDLE;
endmodule

// File: tb/tb_saradc_sar_seq.sv
// tb_saradc_sar_seq: randomized scenario bench against an arithmetic reference of the SAR sequencer
module tb_saradc_sar_seq;
  localparam int NB = 8;
  localparam int AW = 2;
  logic          CLK = 1'b0;
  logic          RST, START, ABORT, CMPO;
  logic [3:0]    SAMPLE_CYC;
  logic [AW-1:0] AVG_LOG2;
  logic          SAMPLE, VALID, BUSY;
  logic [NB-1:0] RESULTP, RESULTN, DATA;
  logic [NB-1:0] target;
  int n_cmp = 0;
  int n_bad = 0;
  int tg[16];

  always #5 CLK = ~CLK;
  assign CMPO = RESULTP <= target;

  saradc_sar_seq #(.NBITS(NB), .AVGW(AW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .SAMPLE_CYC(SAMPLE_CYC),
    .AVG_LOG2(AVG_LOG2), .CMPO(CMPO), .SAMPLE(SAMPLE), .RESULTP(RESULTP),
    .RESULTN(RESULTN), .VALID(VALID), .DATA(DATA), .BUSY(BUSY)
  );

  task automatic test_conv(input string name, input int s, input int a, input bit spam);
    int per = s + NB + 2;
    int n = 1 << a;
    int sum = 0;
    int lat = -1;
    int nv = 0;
    int sbad = 0;
    logic [NB-1:0] dv = 'x, rp = 'x, rn = 'x, exp_d, exp_c;
    logic bz = 1'bx;
    for (int i = 0; i < n; i++) sum += tg[i];
    exp_d = NB'(sum >> a);
    exp_c = NB'(tg[n-1]);
    SAMPLE_CYC = 4'(s);
    AVG_LOG2 = AW'(a);
    target = NB'(tg[0]);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int j = 0; j < n * per + 4; j++) begin
      target = NB'(tg[(j / per < n) ? j / per : n - 1]);
      if (spam) START = (j <= n * per) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (SAMPLE !== ((j < n * per) && (j % per <= s))) sbad++;
      if (VALID === 1'b1) begin
        nv++;
        if (lat < 0) begin
          lat = j; dv = DATA; rp = RESULTP; rn = RESULTN; bz = BUSY;
        end
      end
      @(posedge CLK); #1;
    end
    START = 1'b0;
    n_cmp++; if (lat !== n * per + 1) begin n_bad++; $display("FAIL %s latency got %0d exp %0d", name, lat, n * per + 1); end
    n_cmp++; if (nv !== 1) begin n_bad++; $display("FAIL %s valid_count got %0d exp 1", name, nv); end
    n_cmp++; if (sbad !== 0) begin n_bad++; $display("FAIL %s sample_window bad_cycles got %0d exp 0", name, sbad); end
    n_cmp++; if (dv !== exp_d) begin n_bad++; $display("FAIL %s data got %h exp %h", name, dv, exp_d); end
    n_cmp++; if (rp !== exp_c) begin n_bad++; $display("FAIL %s resultp got %h exp %h", name, rp, exp_c); end
    n_cmp++; if (rn !== ~exp_c) begin n_bad++; $display("FAIL %s resultn got %h exp %h", name, rn, ~exp_c); end
    n_cmp++; if (bz !== 1'b0) begin n_bad++; $display("FAIL %s busy_at_valid got %b exp 0", name, bz); end
    n_cmp++; if (DATA !== exp_d) begin n_bad++; $display("FAIL %s data_hold got %h exp %h", name, DATA, exp_d); end
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++; if (SAMPLE !== 1'b0) begin n_bad++; $display("FAIL %s sample got %b exp 0", name, SAMPLE); end
    n_cmp++; if (RESULTP !== '0) begin n_bad++; $display("FAIL %s resultp got %h exp 00", name, RESULTP); end
    n_cmp++; if (RESULTN !== '1) begin n_bad++; $display("FAIL %s resultn got %h exp ff", name, RESULTN); end
    n_cmp++; if (VALID !== 1'b0) begin n_bad++; $display("FAIL %s valid got %b exp 0", name, VALID); end
    n_cmp++; if (DATA !== '0) begin n_bad++; $display("FAIL %s data got %h exp 00", name, DATA); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL %s busy got %b exp 0", name, BUSY); end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; SAMPLE_CYC = '0; AVG_LOG2 = '0; target = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST = 1'b0;
  endtask

  task automatic test_basic();
    tg[0] = 'hA5;
    test_conv("a5_s0", 0, 0, 0);
  endtask

  task automatic test_extremes();
    tg[0] = 'h00;
    test_conv("zero_s0", 0, 0, 0);
    tg[0] = 'hFF;
    test_conv("full_s15", 15, 0, 0);
  endtask

  task automatic test_avg();
    tg[0] = 10; tg[1] = 11; tg[2] = 12; tg[3] = 13;
    test_conv("avg4", 0, 2, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) tg[i] = int'($urandom_range(0, 255));
      test_conv($sformatf("rand%0d", r), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) tg[i] = int'($urandom_range(0, 255));
    test_conv("start_spam", 3, 1, 1);
  endtask

  task automatic test_abort();
    logic [NB-1:0] old = DATA;
    int nv = 0;
    tg[0] = 'h3C;
    target = NB'(tg[0]);
    SAMPLE_CYC = 4'd2; AVG_LOG2 = '0;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (2 + 1 + 3) begin @(posedge CLK); #1; end
    ABORT = 1'b1;
    @(posedge CLK); #1;
    ABORT = 1'b0;
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL abort_conv busy got %b exp 0", BUSY); end
    for (int j = 0; j < 15; j++) begin
      if (VALID === 1'b1) nv++;
      @(posedge CLK); #1;
    end
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL abort_conv valid_count got %0d exp 0", nv); end
    n_cmp++; if (DATA !== old) begin n_bad++; $display("FAIL abort_conv data got %h exp %h", DATA, old); end
    START = 1'b1; ABORT = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; ABORT = 1'b0;
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL abort_beats_start busy got %b exp 0", BUSY); end
  endtask

  task automatic test_reset_mid();
    tg[0] = 'h77;
    target = NB'(tg[0]);
    SAMPLE_CYC = 4'd1; AVG_LOG2 = '0;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (5) begin @(posedge CLK); #1; end
    n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL reset_mid busy_before got %b exp 1", BUSY); end
    #2 RST = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    #2 RST = 1'b0;
    tg[0] = 'h4E;
    test_conv("after_reset", 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_avg();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
